solution_stepper: RTL and testbench
===================================

Name: solution_stepper

Overview:
- Playback controller between the 8-puzzle solver and the 7-segment display path.
- After the solver asserts solve_done, latches the start board and the solved move list, then locates the blank tile.
- Each debounced press of btn applies one move to the held board, advancing the displayed state until the goal is reached.
- Display logic reads board, step and finished.

Parameters:
MAX_STEPS, 16, capacity of the move list, in moves.
DEB_CYCLES, 4, consecutive cycles btn must hold one level before that level is accepted.
CNT_W, 5, width of step and move_count; must satisfy 2^CNT_W > MAX_STEPS.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
btn  in  1  raw push button, active high, asynchronous to clk
solve_done  in  1  one-cycle pulse from solver: moves, move_count and init_board are valid
init_board  in  36  start board; cell i = bits [4i+3:4i], i = row*3 + col, row 0 = top, tile 0 = blank
moves  in  2*MAX_STEPS  move k = bits [2k+1:2k]; direction the blank travels: 0 up, 1 down, 2 left, 3 right
move_count  in  CNT_W  number of valid moves
board  out  36  current board, same packing as init_board
blank_pos  out  4  index of the blank cell, 0..8
step  out  CNT_W  moves applied so far
busy  out  1  high in LOAD, SCAN and APPLY
finished  out  1  high in DONE
error  out  1  high in ERR

Behaviour:
- Reset is sampled only on a rising clk edge with rst_n=0. It forces: state IDLE, board=0, blank_pos=0, step=0, busy=0, finished=0, error=0, debounce counter=0, accepted level=0, press=0.
- Reset mid-operation, in any state, aborts playback with the same values.
- Input sync: btn passes through a 2-flop synchronizer.
- Debounce: a counter increments while the synchronized btn differs from the accepted level; it clears when they match.
- When the counter reaches DEB_CYCLES-1 while still differing, the accepted level toggles.
- A 0->1 toggle of the accepted level produces press, a 1-cycle pulse.
- Press latency is therefore 2 + DEB_CYCLES cycles after btn rises.
- IDLE:
  - On solve_done, latch init_board into board, latch moves and move_count, then go to LOAD.
  - Presses in IDLE are discarded.
- LOAD (1 cycle):
  - If move_count > MAX_STEPS, go to ERR.
  - Otherwise clear the blank counter and scan index, then go to SCAN.
- SCAN (exactly 9 cycles, one cell per cycle, index 0..8):
  - For each cell equal to 0, increment the blank counter and record its index in blank_pos.
  - After cell 8: exactly one blank goes to READY, or to DONE when move_count=0; any other count goes to ERR.
- READY:
  - On press, go to APPLY.
  - solve_done is ignored in every state except IDLE.
- APPLY (1 cycle):
  - Decode move[step].
  - Legality: up needs blank_pos>=3; down needs blank_pos<=5; left needs blank_pos%3!=0; right needs blank_pos%3!=2.
  - Legal move: swap the blank with the target cell (target = blank_pos -3 / +3 / -1 / +1), set blank_pos to the target, step += 1. Go to DONE if the new step equals move_count, else to READY.
  - Illegal move: board and step unchanged, go to ERR.
- The board update is visible on the cycle after press.
- A press arriving while not in READY is dropped, never queued.
- DONE: finished=1; outputs hold; presses ignored.
- ERR: error=1; board, step and blank_pos hold.
- DONE and ERR are left only by reset.
- step never exceeds move_count and never wraps.

Test Plan:
1. Reset with btn=0 for 3 cycles, release rst_n -> board=0, step=0, blank_pos=0, busy=0, finished=0, error=0.
2. solve_done pulse, init_board cells {1,2,3,4,5,6,7,0,8}, move_count=1, move0=3 (right) -> busy high for 10 cycles, blank_pos=7, READY. btn high 10 cycles -> one cycle after press: board {1,2,3,4,5,6,7,8,0}, blank_pos=8, step=1, finished=1.
3. Six-move solution with btn pulsed 10 cycles high / 10 low seven times (the existing top-level bench cadence) -> step increments 1..6 once per pulse; the seventh pulse is ignored; finished=1, step=6.
4. btn glitch high for 2 cycles with DEB_CYCLES=4 -> no press; board and step unchanged.
5. Blank at index 2 with move0=3 (right) -> after press error=1, board unchanged, step=0. A second board with two 0 tiles -> error=1 at the end of SCAN.
6. move_count=17 -> error=1 after LOAD. Reset asserted during SCAN -> all outputs return to reset values on the next edge, and a later solve_done restarts cleanly.

Source files
------------

// File: rtl/solution_stepper.sv
// Steps a solved 8-puzzle board one move per debounced button press.
// Latches the start board and move list on solve_done, finds the blank, then applies moves.
module solution_stepper #(
  parameter int MAX_STEPS  = 16,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn,
  input  logic                   solve_done,
  input  logic [35:0]            init_board,
  input  logic [2*MAX_STEPS-1:0] moves,
  input  logic [CNT_W-1:0]       move_count,
  output logic [35:0]            board,
  output logic [3:0]             blank_pos,
  output logic [CNT_W-1:0]       step,
  output logic                   busy,
  output logic                   finished,
  output logic                   error
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_APPLY = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic                   sync1_reg, sync2_reg;
  logic [DEB_W-1:0]       deb_cnt_reg;
  logic                   level_reg;
  logic                   press_reg;

  logic [2:0]             state_reg;
  logic [35:0]            board_reg;
  logic [2*MAX_STEPS-1:0] moves_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       step_reg;
  logic [3:0]             blank_pos_reg;
  logic [3:0]             scan_idx_reg;
  logic [1:0]             blank_cnt_reg;

  logic [1:0]             blank_cnt_next;
  logic [1:0]             move_dir;
  logic                   legal;
  logic [3:0]             target;
  logic [3:0]             col;
  logic [3:0]             target_cell;

  // Debounce: the accepted level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      deb_cnt_reg <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
          deb_cnt_reg <= '0;
          level_reg   <= ~level_reg;
          press_reg   <= ~level_reg;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    blank_cnt_next = blank_cnt_reg;
    if (board_reg[4*int'(scan_idx_reg) +: 4] == 4'd0 && blank_cnt_reg != 2'd2)
      blank_cnt_next = blank_cnt_reg + 2'd1;

    move_dir    = moves_reg[2*int'(step_reg) +: 2];
    col         = blank_pos_reg % 4'd3;
    legal       = 1'b0;
    target      = blank_pos_reg;
    case (move_dir)
      2'd0: begin legal = (blank_pos_reg >= 4'd3); target = blank_pos_reg - 4'd3; end
      2'd1: begin legal = (blank_pos_reg <= 4'd5); target = blank_pos_reg + 4'd3; end
      2'd2: begin legal = (col != 4'd0);           target = blank_pos_reg - 4'd1; end
      default: begin legal = (col != 4'd2);        target = blank_pos_reg + 4'd1; end
    endcase
    target_cell = legal ? board_reg[4*int'(target) +: 4] : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      board_reg     <= '0;
      moves_reg     <= '0;
      count_reg     <= '0;
      step_reg      <= '0;
      blank_pos_reg <= '0;
      scan_idx_reg  <= '0;
      blank_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (solve_done) begin
          board_reg <= init_board;
          moves_reg <= moves;
          count_reg <= move_count;
          step_reg  <= '0;
          state_reg <= S_LOAD;
        end
        S_LOAD: begin
          scan_idx_reg  <= '0;
          blank_cnt_reg <= '0;
          state_reg     <= (count_reg > CNT_W'(MAX_STEPS)) ? S_ERR : S_SCAN;
        end
        S_SCAN: begin
          blank_cnt_reg <= blank_cnt_next;
          if (board_reg[4*int'(scan_idx_reg) +: 4] == 4'd0)
            blank_pos_reg <= scan_idx_reg;
          scan_idx_reg <= scan_idx_reg + 4'd1;
          if (scan_idx_reg == 4'd8) begin
            if (blank_cnt_next != 2'd1)       state_reg <= S_ERR;
            else if (count_reg == '0)         state_reg <= S_DONE;
            else                              state_reg <= S_READY;
          end
        end
        S_READY: if (press_reg) state_reg <= S_APPLY;
        S_APPLY: begin
          if (legal) begin
            board_reg[4*int'(blank_pos_reg) +: 4] <= target_cell;
            board_reg[4*int'(target) +: 4]        <= 4'd0;
            blank_pos_reg <= target;
            step_reg      <= step_reg + CNT_W'(1);
            state_reg     <= (step_reg + CNT_W'(1) == count_reg) ? S_DONE : S_READY;
          end else begin
            state_reg <= S_ERR;
          end
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

  assign board     = board_reg;
  assign blank_pos = blank_pos_reg;
  assign step      = step_reg;
  assign busy      = (state_reg == S_LOAD) || (state_reg == S_SCAN) || (state_reg == S_APPLY);
  assign finished  = (state_reg == S_DONE);
  assign error     = (state_reg == S_ERR);

endmodule

// File: tb/tb_solution_stepper.sv
// Directed bench for solution_stepper: one task per scenario with inline expected values.
module tb_solution_stepper;
  localparam int MAX_STEPS = 16;
  localparam int CNT_W     = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   btn;
  logic                   solve_done;
  logic [35:0]            init_board;
  logic [2*MAX_STEPS-1:0] moves;
  logic [CNT_W-1:0]       move_count;
  logic [35:0]            board;
  logic [3:0]             blank_pos;
  logic [CNT_W-1:0]       step;
  logic                   busy;
  logic                   finished;
  logic                   error;

  int n_cmp = 0;
  int n_bad = 0;

  solution_stepper #(.MAX_STEPS(16), .DEB_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .solve_done(solve_done),
    .init_board(init_board), .moves(moves), .move_count(move_count),
    .board(board), .blank_pos(blank_pos), .step(step),
    .busy(busy), .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pack9(input int c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8[3:0], c7[3:0], c6[3:0], c5[3:0], c4[3:0], c3[3:0], c2[3:0], c1[3:0], c0[3:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn = 1'b0; solve_done = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [35:0] b, input logic [2*MAX_STEPS-1:0] m, input int cnt);
    @(negedge clk);
    init_board = b; moves = m; move_count = cnt[CNT_W-1:0]; solve_done = 1'b1;
    @(negedge clk);
    solve_done = 1'b0;
  endtask

  task automatic pulse_btn(input int hi, input int lo);
    btn = 1'b1; cyc(hi);
    btn = 1'b0; cyc(lo);
  endtask

  task automatic wait_not_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cyc(1);
    n_cmp++; if (board !== 36'd0) begin n_bad++; $display("FAIL reset_board got %h want 0", board); end
    n_cmp++; if (step !== 5'd0) begin n_bad++; $display("FAIL reset_step got %0d want 0", step); end
    n_cmp++; if (blank_pos !== 4'd0) begin n_bad++; $display("FAIL reset_blank got %0d want 0", blank_pos); end
    n_cmp++; if ({busy, finished, error} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy, finished, error}); end
    $display("reset: board=%h step=%0d flags=%b", board, step, {busy, finished, error});
  endtask

  task automatic test_single_move();
    int n;
    do_reset();
    load(pack9(1,2,3,4,5,6,7,0,8), 32'd3, 1);
    n_cmp++; if (board !== pack9(1,2,3,4,5,6,7,0,8)) begin n_bad++; $display("FAIL single_latch got %h want %h", board, pack9(1,2,3,4,5,6,7,0,8)); end
    wait_not_busy(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL single_busy_len got %0d want 10", n); end
    n_cmp++; if (blank_pos !== 4'd7) begin n_bad++; $display("FAIL single_scan_blank got %0d want 7", blank_pos); end
    n_cmp++; if ({finished, error} !== 2'b00) begin n_bad++; $display("FAIL single_ready_flags got %b want 00", {finished, error}); end
    pulse_btn(10, 2);
    n_cmp++; if (board !== pack9(1,2,3,4,5,6,7,8,0)) begin n_bad++; $display("FAIL single_board got %h want %h", board, pack9(1,2,3,4,5,6,7,8,0)); end
    n_cmp++; if (blank_pos !== 4'd8) begin n_bad++; $display("FAIL single_blank got %0d want 8", blank_pos); end
    n_cmp++; if (step !== 5'd1) begin n_bad++; $display("FAIL single_step got %0d want 1", step); end
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL single_finished got %b want 1", finished); end
    $display("single_move: busy_len=%0d board=%h step=%0d finished=%b", n, board, step, finished);
  endtask

  task automatic test_six_moves();
    int n;
    logic [2*MAX_STEPS-1:0] m;
    m = '0;
    m[1:0] = 2'd0; m[3:2] = 2'd0; m[5:4] = 2'd2; m[7:6] = 2'd1; m[9:8] = 2'd3; m[11:10] = 2'd1;
    do_reset();
    load(pack9(1,2,3,4,5,6,7,8,0), m, 6);
    wait_not_busy(n);
    for (int k = 1; k <= 7; k++) begin
      pulse_btn(10, 10);
      n_cmp++;
      if (step !== ((k > 6) ? 5'd6 : k[4:0])) begin
        n_bad++; $display("FAIL six_step_%0d got %0d want %0d", k, step, (k > 6) ? 6 : k);
      end
      if (k == 1) begin
        n_cmp++; if (board !== pack9(1,2,3,4,5,0,7,8,6)) begin n_bad++; $display("FAIL six_board1 got %h want %h", board, pack9(1,2,3,4,5,0,7,8,6)); end
      end
      $display("six_moves: pulse %0d step=%0d board=%h", k, step, board);
    end
    n_cmp++; if (board !== pack9(1,5,2,4,3,6,7,8,0)) begin n_bad++; $display("FAIL six_board got %h want %h", board, pack9(1,5,2,4,3,6,7,8,0)); end
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL six_finished got %b want 1", finished); end
  endtask

  task automatic test_glitch();
    int n;
    do_reset();
    load(pack9(1,2,3,4,5,6,7,0,8), 32'd3, 1);
    wait_not_busy(n);
    pulse_btn(2, 12);
    n_cmp++; if (step !== 5'd0) begin n_bad++; $display("FAIL glitch_step got %0d want 0", step); end
    n_cmp++; if (board !== pack9(1,2,3,4,5,6,7,0,8)) begin n_bad++; $display("FAIL glitch_board got %h want %h", board, pack9(1,2,3,4,5,6,7,0,8)); end
    n_cmp++; if ({busy, finished, error} !== 3'b000) begin n_bad++; $display("FAIL glitch_flags got %b want 000", {busy, finished, error}); end
    pulse_btn(10, 2);
    n_cmp++; if (step !== 5'd1) begin n_bad++; $display("FAIL glitch_real_press got %0d want 1", step); end
    $display("glitch: step=%0d board=%h", step, board);
  endtask

  task automatic test_errors();
    int n;
    do_reset();
    load(pack9(1,2,0,3,4,5,6,7,8), 32'd3, 1);
    wait_not_busy(n);
    n_cmp++; if (blank_pos !== 4'd2) begin n_bad++; $display("FAIL illegal_scan_blank got %0d want 2", blank_pos); end
    pulse_btn(10, 2);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL illegal_error got %b want 1", error); end
    n_cmp++; if (board !== pack9(1,2,0,3,4,5,6,7,8)) begin n_bad++; $display("FAIL illegal_board got %h want %h", board, pack9(1,2,0,3,4,5,6,7,8)); end
    n_cmp++; if (step !== 5'd0) begin n_bad++; $display("FAIL illegal_step got %0d want 0", step); end
    $display("illegal_move: error=%b step=%0d board=%h", error, step, board);
    do_reset();
    load(pack9(0,2,0,3,4,5,6,7,8), 32'd3, 1);
    wait_not_busy(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL two_blank_len got %0d want 10", n); end
    n_cmp++; if ({finished, error} !== 2'b01) begin n_bad++; $display("FAIL two_blank_error got %b want 01", {finished, error}); end
    $display("two_blanks: scan_len=%0d error=%b", n, error);
  endtask

  task automatic test_overflow_and_midreset();
    int n;
    do_reset();
    load(pack9(1,2,3,4,5,6,7,8,0), 32'd0, 17);
    cyc(1);
    n_cmp++; if ({busy, error} !== 2'b01) begin n_bad++; $display("FAIL overflow_error got busy,error=%b want 01", {busy, error}); end
    $display("overflow: busy=%b error=%b", busy, error);
    do_reset();
    load(pack9(1,2,3,4,5,6,7,8,0), 32'd0, 1);
    cyc(8);
    rst_n = 1'b0;
    cyc(1);
    n_cmp++; if (board !== 36'd0) begin n_bad++; $display("FAIL midreset_board got %h want 0", board); end
    n_cmp++; if (blank_pos !== 4'd0) begin n_bad++; $display("FAIL midreset_blank got %0d want 0", blank_pos); end
    n_cmp++; if ({busy, finished, error, step} !== 8'd0) begin n_bad++; $display("FAIL midreset_flags got %b want 0", {busy, finished, error, step}); end
    rst_n = 1'b1;
    load(pack9(1,2,3,4,5,6,7,0,8), 32'd3, 1);
    wait_not_busy(n);
    n_cmp++; if (blank_pos !== 4'd7) begin n_bad++; $display("FAIL restart_blank got %0d want 7", blank_pos); end
    pulse_btn(10, 2);
    n_cmp++; if ({finished, step} !== {1'b1, 5'd1}) begin n_bad++; $display("FAIL restart_done got %b/%0d want 1/1", finished, step); end
    $display("midreset_restart: blank=%0d step=%0d finished=%b", blank_pos, step, finished);
  endtask

  initial begin
    rst_n = 1'b0; btn = 1'b0; solve_done = 1'b0;
    init_board = '0; moves = '0; move_count = '0;
    test_reset();
    test_single_move();
    test_six_moves();
    test_glitch();
    test_errors();
    test_overflow_and_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
